// File: rtl/dco_tune_decoder.sv
// dco_tune_decoder: turns the loop-filter tuning word into row/column thermometer
// enables for the DCO capacitor-bank array. Code changes are rate-limited to steps
// of at most MAX_STEP, each followed by SETTLE_CYC hold cycles.
// Optional feature: define DCO_DITHER_EN to add first-order sigma-delta dithering
// of the fractional tuning bits onto the integer code.
module dco_tune_decoder #(
   parameter int unsigned ROW_W      = 3,
   parameter int unsigned COL_W      = 3,
   parameter int unsigned FRAC_W     = 4,
   parameter int unsigned MAX_STEP   = 4,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned RST_CODE   = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ROW_W+COL_W+FRAC_W-1:0]   tune_i,
   input  logic                            tune_valid_i,
   output logic                            tune_ready_o,
   output logic [(2**ROW_W)-1:0]           rowon_o,
   output logic [(2**ROW_W)-1:0]           rowsel_o,
   output logic [(2**COL_W)-1:0]           col_o,
   output logic                            upd_o
);

   localparam int unsigned ROWS  = 2 ** ROW_W;
   localparam int unsigned COLS  = 2 ** COL_W;
   localparam int unsigned INT_W = ROW_W + COL_W;
   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [INT_W-1:0] RST_K    = INT_W'(RST_CODE);

   typedef enum logic [1:0] {StIdle, StStep, StSettle} state_e;

   state_e             r_state;
   logic [INT_W-1:0]   r_cur;
   logic [INT_W-1:0]   r_target;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_upd;
   logic [ROWS-1:0]    r_rowon;
   logic [ROWS-1:0]    r_rowsel;
   logic [COLS-1:0]    r_col;

   logic               w_accept;
   logic               w_do_step;
   logic [INT_W-1:0]   w_tune_int;
   logic [INT_W-1:0]   w_cur_d;
   logic [INT_W-1:0]   w_k;

`ifdef DCO_DITHER_EN
   logic [FRAC_W-1:0]  r_frac;
   logic [FRAC_W-1:0]  r_acc;
   logic [FRAC_W:0]    w_acc_sum;
`else
   logic               w_unused_frac;
   assign w_unused_frac = ^tune_i[FRAC_W-1:0];
`endif

   // Fully enabled rows: every row below the code's row index.
   function automatic logic [ROWS-1:0] f_rowon(input logic [INT_W-1:0] k);
      logic [ROWS-1:0] v;
      for (int unsigned i = 0; i < ROWS; i++) begin
         v[i] = (ROW_W'(i) < k[INT_W-1:COL_W]);
      end
      return v;
   endfunction

   // The single partially enabled row.
   function automatic logic [ROWS-1:0] f_rowsel(input logic [INT_W-1:0] k);
      logic [ROWS-1:0] v;
      for (int unsigned i = 0; i < ROWS; i++) begin
         v[i] = (ROW_W'(i) == k[INT_W-1:COL_W]);
      end
      return v;
   endfunction

   // Enabled columns inside the partial row.
   function automatic logic [COLS-1:0] f_col(input logic [INT_W-1:0] k);
      logic [COLS-1:0] v;
      for (int unsigned j = 0; j < COLS; j++) begin
         v[j] = (COL_W'(j) < k[COL_W-1:0]);
      end
      return v;
   endfunction

   // Move cur toward tgt by at most MAX_STEP; clamping to |diff| means no overshoot
   // and therefore no wrap at either end of the code range.
   function automatic logic [INT_W-1:0] f_step(input logic [INT_W-1:0] cur,
                                               input logic [INT_W-1:0] tgt);
      logic [INT_W:0] diff;
      logic [INT_W:0] mag;
      diff = {1'b0, tgt} - {1'b0, cur};
      mag  = diff[INT_W] ? (~diff + 1'b1) : diff;
      if (32'(mag) > MAX_STEP) begin
         mag = (INT_W+1)'(MAX_STEP);
      end
      return diff[INT_W] ? (cur - mag[INT_W-1:0]) : (cur + mag[INT_W-1:0]);
   endfunction

   assign w_tune_int = tune_i[INT_W+FRAC_W-1:FRAC_W];
   assign w_accept   = tune_valid_i & r_ready;

   // Next integer code and the effective (possibly dithered) code to decode.
   // A step after settling is taken on the same edge the hold interval expires.
   always_comb begin
      w_do_step = (r_state == StStep) ||
                  ((r_state == StSettle) && (r_cnt == '0) && (r_cur != r_target));
      w_cur_d   = w_do_step ? f_step(r_cur, r_target) : r_cur;
`ifdef DCO_DITHER_EN
      w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};
      w_k       = (w_acc_sum[FRAC_W] && (w_cur_d != '1)) ? (w_cur_d + 1'b1) : w_cur_d;
`else
      w_k       = w_cur_d;
`endif
   end

   // Control FSM, code register and registered decode outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cur    <= RST_K;
         r_target <= RST_K;
         r_cnt    <= '0;
         r_ready  <= 1'b1;
         r_upd    <= 1'b0;
         r_rowon  <= f_rowon(RST_K);
         r_rowsel <= f_rowsel(RST_K);
         r_col    <= f_col(RST_K);
`ifdef DCO_DITHER_EN
         r_acc    <= '0;
         r_frac   <= '0;
`endif
      end else begin
         r_cur    <= w_cur_d;
         r_upd    <= w_do_step;
         r_rowon  <= f_rowon(w_k);
         r_rowsel <= f_rowsel(w_k);
         r_col    <= f_col(w_k);
`ifdef DCO_DITHER_EN
         r_acc    <= w_acc_sum[FRAC_W-1:0];
`endif
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_target <= w_tune_int;
`ifdef DCO_DITHER_EN
                  r_frac   <= tune_i[FRAC_W-1:0];
`endif
                  if (w_tune_int != r_cur) begin
                     r_state <= StStep;
                     r_ready <= 1'b0;
                  end
               end
            end
            StStep: begin
               r_cnt   <= CNT_LOAD;
               r_state <= StSettle;
            end
            StSettle: begin
               if (r_cnt == '0) begin
                  if (r_cur != r_target) begin
                     r_cnt <= CNT_LOAD;
                  end else begin
                     r_state <= StIdle;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign tune_ready_o = r_ready;
   assign upd_o        = r_upd;
   assign rowon_o      = r_rowon;
   assign rowsel_o     = r_rowsel;
   assign col_o        = r_col;

endmodule

// File: doc/dco_tune_decoder.md
Name: dco_tune_decoder

Overview:
- Converts the loop-filter tuning word into row/column thermometer enables for the DCO capacitor-bank cell array. The array's per-cell AOI decode gates consume these enables directly.
- Rate-limits code changes with a slew limit and a settle interval, so the DCO sees small, spaced steps.
- Sits between the ADPLL loop filter (upstream, valid/ready) and the capacitor-bank cell array (downstream).

Parameters:
- ROW_W, 3, row address bits; ROWS = 2^ROW_W
- COL_W, 3, column address bits; COLS = 2^COL_W; INT_W = ROW_W+COL_W
- FRAC_W, 4, fractional tuning bits (used only with dither)
- MAX_STEP, 4, max integer code change per update; must be >= 1
- SETTLE_CYC, 4, cycles held after each step before the next step or accept; must be >= 1
- RST_CODE, 32, integer code loaded at reset

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- tune_i  in  INT_W+FRAC_W  tuning word: integer part in the MSBs, fraction in the LSBs
- tune_valid_i  in  1  tune_i valid
- tune_ready_o  out  1  block can accept a new word
- rowon_o  out  ROWS  thermometer of fully enabled rows
- rowsel_o  out  ROWS  one-hot partial row (all zero when code row index = ROWS)
- col_o  out  COLS  thermometer of enabled columns in the partial row
- upd_o  out  1  one-cycle pulse on each integer code change

Behaviour:
- Decode of effective code k:
  - f = k>>COL_W, c = k & (COLS-1).
  - rowon_o[i] = (i < f); rowsel_o[i] = (i == f); col_o[j] = (j < c).
  - All decode outputs are registered and updated on the same edge as the code register.
- Reset (rst_n=0 at an edge):
  - cur = RST_CODE, target = RST_CODE, state IDLE.
  - Outputs = decode(RST_CODE), tune_ready_o = 1, upd_o = 0, dither accumulator = 0.
  - Reset mid-ramp or mid-settle abandons the target.
- States: IDLE, STEP, SETTLE.
  - IDLE: tune_ready_o = 1. On valid&ready at edge N, target <= tune_i integer part and frac <= tune_i fraction.
    - If target == cur: remain IDLE, no upd_o, ready stays 1.
    - Else: go to STEP, ready = 0 from edge N.
  - STEP, one cycle: at edge N+1, cur <= cur + sign(diff)·min(|diff|, MAX_STEP) and outputs are updated. upd_o = 1 for the following cycle. Load counter = SETTLE_CYC-1 and go to SETTLE.
  - SETTLE: decrement each edge. At counter == 0: go to STEP if cur != target, else go to IDLE. tune_ready_o = 1 is registered at that edge (edge N+1+SETTLE_CYC for a single step).
- tune_valid_i while tune_ready_o = 0 is ignored; upstream holds the word.
- Arithmetic:
  - Unsigned codes 0..2^INT_W-1; diff is computed at INT_W+1 bits signed.
  - A step never overshoots the target.
  - Codes never wrap: down-ramps stop at 0, up-ramps stop at 2^INT_W-1.
- Simultaneous reset and valid: reset wins; the word is dropped.

Optional Feature:
- Macro DCO_DITHER_EN.
- Defined: first-order sigma-delta on frac.
  - Every cycle, in all states, acc <= (acc + frac) mod 2^FRAC_W, and carry = overflow.
  - Effective code k = min(cur + carry, 2^INT_W-1), re-decoded and registered every cycle.
  - upd_o pulses only on cur changes, not on dither toggles.
  - frac is replaced at each accept. Reset clears acc and frac.
- Undefined: fraction bits are ignored (truncated), k = cur, and the accumulator is absent.

Test Plan:
- Reset with defaults -> rowon_o=8'b00001111, rowsel_o=8'b00010000, col_o=8'h00, tune_ready_o=1, upd_o=0.
- From 32, accept integer 35 at edge N -> at N+1 col_o=8'b00000111 and rowsel_o unchanged; upd_o high for one cycle; tune_ready_o returns high at N+5.
- From 35, accept 63 -> codes 39,43,47,51,55,59,63, each 4 cycles apart with 7 upd_o pulses. Final rowon_o=8'b01111111, rowsel_o=8'b10000000, col_o=8'b01111111.
- Accept 63 while cur=63 -> no upd_o, tune_ready_o stays 1, outputs unchanged.
- rst_n low during the third step of a 0->40 ramp -> next edge outputs = decode(32), IDLE, ready=1.
- DCO_DITHER_EN, tune_i = {10, 4'd8} -> effective code alternates 10/11 each cycle with no upd_o on toggles. With {63, 4'd15}, the effective code stays at 63 (saturated).
